// File: rtl/multiplier_if.sv
// Operand/result bundle for the shift-add multiplier.
// The master issues operands with a start pulse; the slave returns busy/done/product.
interface multiplier_if #(
    parameter int M = 26,
    parameter int N = 14
);
    logic           i_start;
    logic [M-1:0]   i_multiplicand;
    logic [N-1:0]   i_multiplier;
    logic [N-1:0]   i_addend;
    logic           o_busy;
    logic           o_done;
    logic [M+N-1:0] o_product;

    modport master (
        output i_start,
        output i_multiplicand,
        output i_multiplier,
        output i_addend,
        input  o_busy,
        input  o_done,
        input  o_product
    );

    modport slave (
        input  i_start,
        input  i_multiplicand,
        input  i_multiplier,
        input  i_addend,
        output o_busy,
        output o_done,
        output o_product
    );
endinterface

// File: rtl/multiplier.sv
// Sequential shift-add multiplier with addend: product = A*B + R.
// Retires one multiplier bit per clock, LSB first; fixed N+1 cycle latency.
module multiplier #(
    parameter int M = 26,
    parameter int N = 14
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    multiplier_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_ADD
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [M-1:0]   r_a;
    logic [N-1:0]   r_r;
    logic [M-1:0]   r_hi;
    logic [N-1:0]   r_lo;
    logic [4:0]     r_count;
    logic           r_done;
    logic [M+N-1:0] r_product;
    logic [M:0]     w_sum;
    logic [M+N:0]   w_cat;
    logic           w_last;

    assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    // Concatenate then drop lo[0]; also covers N == 1 without a zero-width slice.
    assign w_cat  = {w_sum, r_lo};
    assign w_last = (r_count == 5'(N - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.i_start) w_next = S_MUL;
            S_MUL:   if (w_last) w_next = S_ADD;
            S_ADD:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a       <= '0;
            r_r       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_a     <= bus.i_multiplicand;
                        r_lo    <= bus.i_multiplier;
                        r_r     <= bus.i_addend;
                        r_hi    <= '0;
                        r_count <= '0;
                    end
                end
                S_MUL: begin
                    {r_hi, r_lo} <= w_cat[M+N:1];
                    r_count      <= r_count + 5'd1;
                end
                S_ADD: begin
                    r_product <= {r_hi, r_lo} + {{M{1'b0}}, r_r};
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy    = (r_state != S_IDLE);
    assign bus.o_done    = r_done;
    assign bus.o_product = r_product;
endmodule
